reg_access_ctrl: RTL and testbench



---
 rtl/reg_access_pkg.sv | 24 ++
 rtl/reg_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_reg_access_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_pkg.sv
// Shared types and constants for the serial register-access controller.
// Field widths, default opcodes and the controller state encoding.
package reg_access_pkg;

  localparam int OP_WIDTH     = 8;
  localparam int ADDR_WIDTH   = 8;
  localparam int DATA_WIDTH   = 32;
  localparam int RD_SHIFT_LEN = 32;
  localparam int CNT_WIDTH    = 6;

  localparam logic [OP_WIDTH-1:0] OP_WRITE_DEF = 8'h01;
  localparam logic [OP_WIDTH-1:0] OP_READ_DEF  = 8'h02;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_RDLATCH,
    ST_RDSHIFT,
    ST_RDDONE
  } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Deserialises MSB-first opcode/address/data frames and drives the shared register bus,
// including the 32-cycle serial readback of the addressed register.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter logic [OP_WIDTH-1:0] OP_WRITE = OP_WRITE_DEF,
  parameter logic [OP_WIDTH-1:0] OP_READ  = OP_READ_DEF
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic                  serIn,
  input  logic                  serValid,
  input  logic                  frameAbort,
  input  logic                  shiftIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  latchIn,
  output logic                  latchOut,
  output logic                  shiftEn,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdValid,
  output logic                  cmdErr,
  output logic                  busy,
  output state_t                state_dbg
);

  localparam logic [CNT_WIDTH-1:0] OP_LAST   = CNT_WIDTH'(OP_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] RD_LAST   = CNT_WIDTH'(RD_SHIFT_LEN - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [RD_SHIFT_LEN-1:0] rd_shift_q, rd_shift_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    latch_in_q, latch_in_d;
  logic                    latch_out_q, latch_out_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    cmd_err_q, cmd_err_d;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CMD;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_shift_q  <= '0;
      rd_data_q   <= '0;
      latch_in_q  <= 1'b0;
      latch_out_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_shift_q  <= rd_shift_d;
      rd_data_q   <= rd_data_d;
      latch_in_q  <= latch_in_d;
      latch_out_q <= latch_out_d;
      rd_valid_q  <= rd_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Strobes are decided one edge early so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_shift_d  = rd_shift_q;
    rd_data_d   = rd_data_q;
    latch_in_d  = 1'b0;
    latch_out_d = 1'b0;
    rd_valid_d  = 1'b0;
    cmd_err_d   = 1'b0;

    if (frameAbort) begin
      state_d = ST_CMD;
    end else begin
      case (state_q)
        ST_CMD: if (serValid) begin
          op_d  = {op_q[OP_WIDTH-2:0], serIn};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OP_LAST) begin
            cnt_d = '0;
            if (op_d == OP_WRITE || op_d == OP_READ) state_d = ST_ADDR;
            else cmd_err_d = 1'b1;
          end
        end
        ST_ADDR: if (serValid) begin
          addr_d = {addr_q[ADDR_WIDTH-2:0], serIn};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            // Only the two legal opcodes can reach this state.
            if (op_q == OP_READ) begin
              state_d     = ST_RDLATCH;
              latch_out_d = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: if (serValid) begin
          data_d = {data_q[DATA_WIDTH-2:0], serIn};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            state_d    = ST_WRITE;
            latch_in_d = 1'b1;
          end
        end
        ST_WRITE:   state_d = ST_CMD;
        ST_RDLATCH: state_d = ST_RDSHIFT;
        ST_RDSHIFT: begin
          rd_shift_d = {rd_shift_q[RD_SHIFT_LEN-2:0], shiftIn};
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == RD_LAST) begin
            // Publish the word on entry to RDDONE so it lines up with rdValid.
            state_d    = ST_RDDONE;
            rd_data_d  = rd_shift_d;
            rd_valid_d = 1'b1;
          end
        end
        ST_RDDONE: state_d = ST_CMD;
        default:   state_d = ST_CMD;
      endcase
    end

    if (state_d != state_q || frameAbort) cnt_d = '0;
  end

  assign dataOut   = data_q;
  assign addrOut   = addr_q;
  assign latchIn   = latch_in_q;
  assign latchOut  = latch_out_q;
  assign rdData    = rd_data_q;
  assign rdValid   = rd_valid_q;
  assign cmdErr    = cmd_err_q;
  assign shiftEn   = (state_q == ST_RDSHIFT) && !frameAbort;
  assign busy      = (state_q != ST_CMD);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: table of frames against a stub register bank,
// plus abort and async-reset sequences.
module tb_reg_access_ctrl;
  import reg_access_pkg::*;

  localparam logic [7:0] T_OP_WR = 8'h01;
  localparam logic [7:0] T_OP_RD = 8'h02;

  logic        bclk = 1'b0;
  logic        rst, serIn, serValid, frameAbort, shiftIn;
  logic [31:0] dataOut, rdData;
  logic [7:0]  addrOut;
  logic        latchIn, latchOut, shiftEn, rdValid, cmdErr, busy;
  state_t      state_dbg;

  reg_access_ctrl dut (
    .bclk(bclk), .rst(rst), .serIn(serIn), .serValid(serValid), .frameAbort(frameAbort),
    .shiftIn(shiftIn), .dataOut(dataOut), .addrOut(addrOut), .latchIn(latchIn),
    .latchOut(latchOut), .shiftEn(shiftEn), .rdData(rdData), .rdValid(rdValid),
    .cmdErr(cmdErr), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 bclk = ~bclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stub register bank: written on latchIn, loaded into a shifter on latchOut.
  logic [31:0] stub_mem [256];
  logic [31:0] stub_sr;
  always @(posedge bclk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) stub_mem[i] <= 32'h0;
      stub_mem[8'h3C] <= 32'h12345678;
      stub_sr <= 32'h0;
    end else begin
      if (latchIn) stub_mem[addrOut] <= dataOut;
      if (latchOut) stub_sr <= stub_mem[addrOut];
      else if (shiftEn) stub_sr <= {stub_sr[30:0], 1'b0};
    end
  end
  assign shiftIn = stub_sr[31];

  // scoreboard
  logic [39:0] wr_exp_q[$];
  logic [31:0] exp_q[$];
  int          err_pending = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lo_cyc = 0;
  int          se_cnt = 0;
  bit          prev_latch = 0;
  logic [31:0] last_rd_exp = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [39:0] w;
    cyc++;
    if (latchIn || latchOut || rdValid || cmdErr)
      chk("one_strobe", $countones({latchIn, latchOut, rdValid, cmdErr}), 1);
    if (prev_latch) chk("busy_after_latchIn", busy, 0);
    prev_latch = latchIn;
    if (latchIn) begin
      chk("latchIn_expected", wr_exp_q.size() != 0, 1);
      if (wr_exp_q.size() != 0) begin
        w = wr_exp_q.pop_front();
        chk("write_addr_data", {addrOut, dataOut}, w);
      end
    end
    if (latchOut) begin
      lo_cyc = cyc;
      se_cnt = 0;
    end
    if (shiftEn) se_cnt++;
    if (rdValid) begin
      chk("rdValid_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        last_rd_exp = exp_q.pop_front();
        chk("rdData", rdData, last_rd_exp);
      end
      chk("rdValid_latency", cyc - lo_cyc, 33);
      chk("shiftEn_cycles", se_cnt, 32);
    end
    if (cmdErr) begin
      chk("cmdErr_expected", err_pending != 0, 1);
      if (err_pending != 0) err_pending--;
    end
  endtask

  // driver tasks: all time advances through tick, inputs change at posedge+1
  task automatic tick();
    @(negedge bclk);
    monitor();
    @(posedge bclk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--) begin
      int g;
      g = $urandom_range(maxgap, 0);
      repeat (g) begin
        serValid = 1'b0;
        serIn    = 1'($urandom_range(1, 0));
        tick();
      end
      serValid = 1'b1;
      serIn    = v[i];
      tick();
    end
    serValid = 1'b0;
  endtask

  task automatic wait_idle(input bit junk);
    for (int k = 0; k < 100 && busy; k++) begin
      if (junk) begin
        serValid = 1'($urandom_range(1, 0));
        serIn    = 1'($urandom_range(1, 0));
      end
      tick();
    end
    serValid = 1'b0;
    chk("frame_done", busy, 0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          maxgap;
    bit          junk;
  } vec_t;

  task automatic run_vec(input vec_t v);
    if (v.op == T_OP_WR) wr_exp_q.push_back({v.addr, v.data});
    else if (v.op == T_OP_RD) exp_q.push_back(v.exp_rd);
    else err_pending++;
    send_bits({24'h0, v.op}, 8, v.maxgap);
    if (v.op == T_OP_WR || v.op == T_OP_RD) begin
      send_bits({24'h0, v.addr}, 8, v.maxgap);
      if (v.op == T_OP_WR) send_bits(v.data, 32, v.maxgap);
    end else begin
      chk("cmdErr_timing", cmdErr, 1);
    end
    wait_idle(v.junk);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'h02, 8'h3C, 32'h0,        32'h12345678, 0, 1'b0};
    vecs[1]  = '{8'h01, 8'h3C, 32'hDEADBEEF, 32'h0,        0, 1'b0};
    vecs[2]  = '{8'h02, 8'h3C, 32'h0,        32'hDEADBEEF, 0, 1'b0};
    vecs[3]  = '{8'h7F, 8'h00, 32'h0,        32'h0,        0, 1'b0};
    vecs[4]  = '{8'h01, 8'h10, 32'hA5A50F0F, 32'h0,        5, 1'b1};
    vecs[5]  = '{8'h02, 8'h10, 32'h0,        32'hA5A50F0F, 5, 1'b1};
    vecs[6]  = '{8'h02, 8'h3C, 32'h0,        32'hDEADBEEF, 3, 1'b1};
    vecs[7]  = '{8'h01, 8'h00, 32'hFFFFFFFF, 32'h0,        2, 1'b0};
    vecs[8]  = '{8'h02, 8'h00, 32'h0,        32'hFFFFFFFF, 0, 1'b1};
    vecs[9]  = '{8'h02, 8'h55, 32'h0,        32'h00000000, 1, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 32'h0,        32'h0,        2, 1'b0};
    vecs[11] = '{8'h01, 8'hFF, 32'h00000001, 32'h0,        4, 1'b1};
    vecs[12] = '{8'h02, 8'hFF, 32'h0,        32'h00000001, 0, 1'b0};
    vecs[13] = '{8'h03, 8'h00, 32'h0,        32'h0,        0, 1'b0};

    rst = 1'b1; serIn = 1'b0; serValid = 1'b0; frameAbort = 1'b0;
    repeat (3) tick();
    chk("reset_dataOut", dataOut, 0);
    chk("reset_addrOut", addrOut, 0);
    chk("reset_rdData", rdData, 0);
    chk("reset_strobes", {latchIn, latchOut, shiftEn, rdValid, cmdErr, busy}, 0);
    chk("reset_state", state_dbg, ST_CMD);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // abort after 20 data bits: no write must happen
    send_bits({24'h0, T_OP_WR}, 8, 0);
    send_bits(32'h20, 8, 0);
    send_bits(32'hCAFEF, 20, 1);
    chk("pre_abort_state", state_dbg, ST_DATA);
    frameAbort = 1'b1;
    tick();
    frameAbort = 1'b0;
    chk("abort_write_state", state_dbg, ST_CMD);
    run_vec('{8'h02, 8'h20, 32'h0, 32'h00000000, 0, 1'b0});

    // abort in read shift cycle 10: shiftEn drops at once, rdData held
    send_bits({24'h0, T_OP_RD}, 8, 0);
    send_bits(32'h3C, 8, 0);
    chk("rdlatch_state", state_dbg, ST_RDLATCH);
    repeat (10) tick();
    chk("shiftEn_before_abort", shiftEn, 1);
    frameAbort = 1'b1;
    #1;
    chk("shiftEn_abort", shiftEn, 0);
    tick();
    frameAbort = 1'b0;
    chk("abort_read_state", state_dbg, ST_CMD);
    chk("abort_read_rdData", rdData, last_rd_exp);
    repeat (40) tick();
    chk("abort_read_rdData_held", rdData, last_rd_exp);

    // async reset mid-DATA
    send_bits({24'h0, T_OP_WR}, 8, 0);
    send_bits(32'h55, 8, 0);
    send_bits(32'h3FF, 10, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_dataOut", dataOut, 0);
    chk("areset_addrOut", addrOut, 0);
    chk("areset_busy_strobes", {latchIn, latchOut, shiftEn, rdValid, cmdErr, busy}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_vec('{8'h01, 8'h55, 32'h00000001, 32'h0, 0, 1'b0});
    run_vec('{8'h02, 8'h55, 32'h0, 32'h00000001, 2, 1'b1});

    repeat (5) tick();
    chk("wr_queue_empty", wr_exp_q.size(), 0);
    chk("rd_queue_empty", exp_q.size(), 0);
    chk("cmdErr_all_seen", err_pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
